// File: rtl/axi_burst_master_pkg.sv
// Shared encodings for the AXI burst master.
// Holds the AXI burst/response/attribute constants, the controller state
// enumeration and a helper that picks the worse of two AXI responses.
package axi_burst_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR   = 2'b10;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
  localparam int         AXI_4K_BYTES      = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R
  } state_e;

  // AXI response codes rank by severity numerically (DECERR > SLVERR > EXOKAY > OKAY).
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master.
// Accepts one command (address, beats-1, direction) at a time, issues the
// address phase, streams write data from s_wr_* or read data to m_rd_*, and
// reports the worst response plus a protocol/boundary error as a one-cycle
// status pulse. Bursts that would cross a 4 KB page are rejected without
// touching the bus.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   cmd_*             - command handshake (addr, len, write, valid/ready)
//   s_wr_*            - write data stream in (data, strb, valid/ready)
//   m_rd_*            - read data stream out (data, last, valid/ready)
//   sts_*             - status pulse (resp, err, valid)
//   m_axi_*           - AXI4 master interface (AW, W, B, AR, R channels)
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | cmd_ready high, waiting for a command
// ST_AW   | awvalid held with stable fields until awready
// ST_W    | write beats passed through, down-counter tracks last beat
// ST_B    | bready high, waiting for the write response
// ST_AR   | arvalid held with stable fields until arready
// ST_R    | read beats passed through, down-counter generates last
module axi_burst_master
  import axi_burst_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  cmd_write,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_wr_data,
  input  logic [STRB_WIDTH-1:0] s_wr_strb,
  input  logic                  s_wr_valid,
  output logic                  s_wr_ready,
  output logic [DATA_WIDTH-1:0] m_rd_data,
  output logic                  m_rd_last,
  output logic                  m_rd_valid,
  input  logic                  m_rd_ready,
  output logic [1:0]            sts_resp,
  output logic                  sts_err,
  output logic                  sts_valid,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0]            AXI_SIZE  = 3'($clog2(STRB_WIDTH));
  localparam logic [ID_WIDTH-1:0]   AXI_ID_V  = ID_WIDTH'(AXI_ID);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  awvalid_q, awvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [1:0]            resp_acc_q, resp_acc_d;
  logic                  err_acc_q, err_acc_d;
  logic                  sts_valid_q, sts_valid_d;
  logic                  sts_err_q, sts_err_d;
  logic [1:0]            sts_resp_q, sts_resp_d;

  logic [ADDR_WIDTH-1:0] cmd_addr_al;
  logic [31:0]           cmd_off;
  logic [31:0]           cmd_span;
  logic                  cmd_cross;
  logic                  beat_last;
  logic                  w_hs;
  logic                  r_hs;
  logic                  r_err;
  logic [1:0]            resp_new;
  logic                  err_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      resp_acc_q  <= AXI_RESP_OKAY;
      err_acc_q   <= 1'b0;
      sts_valid_q <= 1'b0;
      sts_err_q   <= 1'b0;
      sts_resp_q  <= AXI_RESP_OKAY;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      awvalid_q   <= awvalid_d;
      arvalid_q   <= arvalid_d;
      resp_acc_q  <= resp_acc_d;
      err_acc_q   <= err_acc_d;
      sts_valid_q <= sts_valid_d;
      sts_err_q   <= sts_err_d;
      sts_resp_q  <= sts_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    awvalid_d   = awvalid_q;
    arvalid_d   = arvalid_q;
    resp_acc_d  = resp_acc_q;
    err_acc_d   = err_acc_q;
    sts_valid_d = 1'b0;
    sts_err_d   = sts_err_q;
    sts_resp_d  = sts_resp_q;

    cmd_addr_al = cmd_addr & ADDR_MASK;
    cmd_off     = 32'(cmd_addr_al) & 32'h0000_0FFF;
    cmd_span    = (32'(cmd_len) + 32'd1) * 32'(STRB_WIDTH);
    cmd_cross   = (cmd_off + cmd_span) > 32'(AXI_4K_BYTES);

    // The down-counter holds remaining beats after the current one.
    beat_last = (cnt_q == 8'd0);
    w_hs      = (state_q == ST_W) && s_wr_valid && m_axi_wready;
    r_hs      = (state_q == ST_R) && m_axi_rvalid && m_rd_ready;
    r_err     = (m_axi_rlast != beat_last) || (m_axi_rid != AXI_ID_V);
    resp_new  = resp_max(resp_acc_q, m_axi_rresp);
    err_new   = err_acc_q | r_err;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d     = cmd_addr_al;
          len_d      = cmd_len;
          cnt_d      = cmd_len;
          resp_acc_d = AXI_RESP_OKAY;
          err_acc_d  = 1'b0;
          if (cmd_cross) begin
            sts_valid_d = 1'b1;
            sts_err_d   = 1'b1;
            sts_resp_d  = AXI_RESP_SLVERR;
          end else if (cmd_write) begin
            state_d   = ST_AW;
            awvalid_d = 1'b1;
          end else begin
            state_d   = ST_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_AW: begin
        if (m_axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (w_hs) begin
          if (beat_last) state_d = ST_B;
          else           cnt_d   = cnt_q - 8'd1;
        end
      end
      ST_B: begin
        if (m_axi_bvalid) begin
          state_d     = ST_IDLE;
          sts_valid_d = 1'b1;
          sts_resp_d  = m_axi_bresp;
          sts_err_d   = (m_axi_bid != AXI_ID_V);
        end
      end
      ST_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (r_hs) begin
          resp_acc_d = resp_new;
          err_acc_d  = err_new;
          // Completion follows our own beat count; a misplaced rlast only flags an error.
          if (beat_last) begin
            state_d     = ST_IDLE;
            sts_valid_d = 1'b1;
            sts_resp_d  = resp_new;
            sts_err_d   = err_new;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE) && !rst;

  assign s_wr_ready   = (state_q == ST_W) && m_axi_wready;
  assign m_axi_wvalid = (state_q == ST_W) && s_wr_valid;
  assign m_axi_wdata  = s_wr_data;
  assign m_axi_wstrb  = s_wr_strb;
  assign m_axi_wlast  = (state_q == ST_W) && beat_last;
  assign m_axi_bready = (state_q == ST_B);

  assign m_rd_valid   = (state_q == ST_R) && m_axi_rvalid;
  assign m_axi_rready = (state_q == ST_R) && m_rd_ready;
  assign m_rd_data    = m_axi_rdata;
  assign m_rd_last    = (state_q == ST_R) && beat_last;

  assign m_axi_awid    = AXI_ID_V;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_DEFAULT;
  assign m_axi_awprot  = AXI_PROT_DEFAULT;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_arid    = AXI_ID_V;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_arprot  = AXI_PROT_DEFAULT;
  assign m_axi_arvalid = arvalid_q;

  assign sts_valid = sts_valid_q;
  assign sts_err   = sts_err_q;
  assign sts_resp  = sts_resp_q;

endmodule

// File: tb/tb_axi_burst_master.sv
module tb_axi_burst_master;

  logic        clk, rst;
  logic [12:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_write, cmd_valid, cmd_ready;
  logic [31:0] s_wr_data;
  logic [3:0]  s_wr_strb;
  logic        s_wr_valid, s_wr_ready;
  logic [31:0] m_rd_data;
  logic        m_rd_last, m_rd_valid, m_rd_ready;
  logic [1:0]  sts_resp;
  logic        sts_err, sts_valid;
  logic [7:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [12:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic        m_axi_awlock, m_axi_arlock;
  logic [3:0]  m_axi_awcache, m_axi_arcache;
  logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_write(cmd_write),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_wr_data(s_wr_data), .s_wr_strb(s_wr_strb), .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready),
    .m_rd_data(m_rd_data), .m_rd_last(m_rd_last), .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready),
    .sts_resp(sts_resp), .sts_err(sts_err), .sts_valid(sts_valid),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // ---------------- AXI RAM slave model ----------------
  logic [31:0] mem [2048];
  bit          slv_rnd = 0;
  int          slv_rlast_beat = -1;
  int          slv_rresp_beat = -1;
  logic [7:0]  slv_id = 8'h00;

  bit          w_active, b_pending, r_active;
  logic [12:0] w_addr, r_addr;
  logic [7:0]  r_len;
  int          r_idx;
  bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic [12:0] cap_awaddr, cap_araddr;
  logic [7:0]  cap_arlen;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_wlast;

  int          aw_cnt, ar_cnt, w_beats, wlast_cnt, wlast_pos;
  bit          any_addr_valid;
  logic [12:0] last_awaddr, last_araddr;
  logic [7:0]  last_awlen;
  logic [2:0]  last_awsize;
  logic [1:0]  last_awburst;
  logic [3:0]  last_awcache;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    {w_active, b_pending, r_active, hs_aw, hs_w, hs_b, hs_ar, hs_r} = '0;
    w_addr = '0; r_addr = '0; r_len = '0; r_idx = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    m_axi_rlast = 0;
    forever begin
      @(negedge clk);
      if (hs_aw) begin w_active = 1; w_addr = cap_awaddr; end
      if (hs_w) begin
        for (int k = 0; k < 4; k++)
          if (cap_wstrb[k]) mem[w_addr[12:2]][8*k +: 8] = cap_wdata[8*k +: 8];
        w_addr = w_addr + 13'd4;
        if (cap_wlast) begin w_active = 0; b_pending = 1; end
      end
      if (hs_b) b_pending = 0;
      if (hs_ar) begin r_active = 1; r_addr = cap_araddr; r_len = cap_arlen; r_idx = 0; end
      if (hs_r) begin
        r_idx++;
        if (r_idx > int'(r_len)) r_active = 0;
      end
      m_axi_awready = !w_active && !b_pending && (slv_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      m_axi_wready  = w_active && (slv_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      m_axi_bvalid  = b_pending;
      m_axi_bid     = slv_id;
      m_axi_bresp   = 2'b00;
      m_axi_arready = !r_active && (slv_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      m_axi_rvalid  = r_active;
      m_axi_rid     = slv_id;
      m_axi_rdata   = mem[11'(int'(r_addr[12:2]) + r_idx)];
      m_axi_rlast   = (slv_rlast_beat >= 0) ? (r_idx == slv_rlast_beat) : (r_idx == int'(r_len));
      m_axi_rresp   = (r_idx == slv_rresp_beat) ? 2'b10 : 2'b00;
      #1;
      if (rst) begin
        {w_active, b_pending, r_active, hs_aw, hs_w, hs_b, hs_ar, hs_r} = '0;
        r_idx = 0;
      end else begin
        hs_aw = m_axi_awvalid && m_axi_awready;
        hs_w  = m_axi_wvalid && m_axi_wready;
        hs_b  = m_axi_bvalid && m_axi_bready;
        hs_ar = m_axi_arvalid && m_axi_arready;
        hs_r  = m_axi_rvalid && m_axi_rready;
        if (m_axi_awvalid || m_axi_arvalid) any_addr_valid = 1;
        if (hs_aw) begin
          cap_awaddr = m_axi_awaddr; aw_cnt++;
          last_awaddr = m_axi_awaddr; last_awlen = m_axi_awlen; last_awsize = m_axi_awsize;
          last_awburst = m_axi_awburst; last_awcache = m_axi_awcache;
        end
        if (hs_w) begin
          cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; cap_wlast = m_axi_wlast;
          w_beats++;
          if (m_axi_wlast) begin
            wlast_cnt++;
            if (wlast_pos < 0) wlast_pos = w_beats - 1;
          end
        end
        if (hs_ar) begin
          cap_araddr = m_axi_araddr; cap_arlen = m_axi_arlen; ar_cnt++; last_araddr = m_axi_araddr;
        end
      end
    end
  end

  task automatic clear_logs();
    @(negedge clk);
    aw_cnt = 0; ar_cnt = 0; w_beats = 0; wlast_cnt = 0; wlast_pos = -1; any_addr_valid = 0;
    last_awaddr = '0; last_araddr = '0; last_awlen = '0; last_awsize = '0;
    last_awburst = '0; last_awcache = '0;
  endtask

  // ---------------- command driver ----------------
  logic [31:0] wr_data [256];
  logic [3:0]  wr_strb [256];
  logic [31:0] r_rd_data [256];
  logic        r_rd_last [256];
  int          r_rd_n, r_gap;
  bit          r_timeout, r_busy_ready, r_ready_at_sts, r_sts_err;
  logic [1:0]  r_sts_resp;

  task automatic run_cmd(input logic [12:0] addr, input logic [7:0] len, input bit wr, input bit rnd);
    int  b = 0;
    int  cyc = 0;
    int  last_hs = 0;
    bit  accepted = 0;
    bit  done = 0;
    r_rd_n = 0; r_busy_ready = 0; r_gap = -1; r_ready_at_sts = 0; r_sts_err = 0; r_sts_resp = 2'b00;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cmd_addr = addr; cmd_len = len; cmd_write = wr; cmd_valid = !accepted;
      s_wr_valid = wr && accepted && (b <= int'(len)) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      s_wr_data  = wr_data[b[7:0]];
      s_wr_strb  = wr_strb[b[7:0]];
      m_rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (accepted && sts_valid) begin
        done = 1;
        r_gap = cyc - last_hs;
        r_sts_err = sts_err;
        r_sts_resp = sts_resp;
        r_ready_at_sts = cmd_ready;
      end else begin
        if (accepted && cmd_ready) r_busy_ready = 1;
        if (!accepted && cmd_ready) begin accepted = 1; last_hs = cyc; end
        if (wr && s_wr_valid && s_wr_ready) begin b++; last_hs = cyc; end
        if (!wr && m_rd_valid && m_rd_ready) begin
          if (r_rd_n < 256) begin
            r_rd_data[r_rd_n] = m_rd_data;
            r_rd_last[r_rd_n] = m_rd_last;
          end
          r_rd_n++;
          last_hs = cyc;
        end
      end
      cyc++;
    end
    cmd_valid = 0; s_wr_valid = 0; m_rd_ready = 0;
    r_timeout = !done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); else n_pass++;
    n_total++; if (m_axi_awvalid !== 1'b0 || m_axi_arvalid !== 1'b0)
      $display("FAIL reset_addr_valid: aw %b ar %b want 0", m_axi_awvalid, m_axi_arvalid); else n_pass++;
    n_total++; if (m_axi_bready !== 1'b0) $display("FAIL reset_bready: got %b want 0", m_axi_bready); else n_pass++;
    n_total++; if (sts_valid !== 1'b0 || sts_err !== 1'b0 || sts_resp !== 2'b00)
      $display("FAIL reset_status: v %b e %b r %b want 0 0 00", sts_valid, sts_err, sts_resp); else n_pass++;
    @(negedge clk);
    rst = 0;
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_write_burst();
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
    clear_logs();
    run_cmd(13'h010, 8'd3, 1'b1, 1'b0);
    n_total++; if (r_timeout) $display("FAIL wr_timeout: no status pulse"); else n_pass++;
    n_total++; if (aw_cnt !== 1 || last_awaddr !== 13'h010 || last_awlen !== 8'd3)
      $display("FAIL wr_aw: cnt %0d addr %h len %0d want 1 010 3", aw_cnt, last_awaddr, last_awlen); else n_pass++;
    n_total++; if (last_awsize !== 3'd2 || last_awburst !== 2'b01 || last_awcache !== 4'b0011)
      $display("FAIL wr_aw_attr: size %0d burst %b cache %b want 2 01 0011", last_awsize, last_awburst, last_awcache); else n_pass++;
    n_total++; if (w_beats !== 4 || wlast_cnt !== 1 || wlast_pos !== 3)
      $display("FAIL wr_wlast: beats %0d lasts %0d pos %0d want 4 1 3", w_beats, wlast_cnt, wlast_pos); else n_pass++;
    n_total++; if (r_sts_err !== 1'b0 || r_sts_resp !== 2'b00)
      $display("FAIL wr_status: err %b resp %b want 0 00", r_sts_err, r_sts_resp); else n_pass++;
    n_total++; if (r_busy_ready !== 1'b0 || r_ready_at_sts !== 1'b1)
      $display("FAIL wr_cmd_ready: busy %b at_sts %b want 0 1", r_busy_ready, r_ready_at_sts); else n_pass++;
  endtask

  task automatic test_read_burst();
    clear_logs();
    run_cmd(13'h010, 8'd3, 1'b0, 1'b0);
    n_total++; if (r_timeout || r_rd_n !== 4)
      $display("FAIL rd_count: timeout %b beats %0d want 0 4", r_timeout, r_rd_n); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (r_rd_data[i] !== 32'(i + 1) || r_rd_last[i] !== (i == 3))
        $display("FAIL rd_beat%0d: data %h last %b want %h %b", i, r_rd_data[i], r_rd_last[i], i + 1, i == 3); else n_pass++;
    end
    n_total++; if (r_gap !== 1) $display("FAIL rd_sts_latency: got %0d cycles want 1", r_gap); else n_pass++;
    n_total++; if (last_araddr !== 13'h010 || r_sts_err !== 1'b0 || r_sts_resp !== 2'b00)
      $display("FAIL rd_status: araddr %h err %b resp %b want 010 0 00", last_araddr, r_sts_err, r_sts_resp); else n_pass++;
  endtask

  task automatic test_4k_boundary();
    clear_logs();
    run_cmd(13'hFF8, 8'd3, 1'b1, 1'b0);
    n_total++; if (any_addr_valid !== 1'b0 || w_beats !== 0)
      $display("FAIL 4k_wr_bus: addr_valid %b beats %0d want 0 0", any_addr_valid, w_beats); else n_pass++;
    n_total++; if (r_timeout || r_sts_err !== 1'b1 || r_sts_resp !== 2'b10 || r_gap !== 1)
      $display("FAIL 4k_wr_status: err %b resp %b gap %0d want 1 10 1", r_sts_err, r_sts_resp, r_gap); else n_pass++;
    clear_logs();
    run_cmd(13'hFFC, 8'd1, 1'b0, 1'b0);
    n_total++; if (any_addr_valid !== 1'b0 || r_sts_err !== 1'b1 || r_sts_resp !== 2'b10)
      $display("FAIL 4k_rd_reject: addr_valid %b err %b resp %b want 0 1 10", any_addr_valid, r_sts_err, r_sts_resp); else n_pass++;
    clear_logs();
    run_cmd(13'hFF8, 8'd1, 1'b0, 1'b0);
    n_total++; if (r_timeout || ar_cnt !== 1 || r_rd_n !== 2 || r_sts_err !== 1'b0)
      $display("FAIL 4k_edge_ok: ar %0d beats %0d err %b want 1 2 0", ar_cnt, r_rd_n, r_sts_err); else n_pass++;
  endtask

  task automatic test_random_stream();
    int bad = 0;
    for (int i = 0; i < 8; i++) begin wr_data[i] = 32'hA0 + 32'(i); wr_strb[i] = 4'hF; end
    slv_rnd = 1;
    clear_logs();
    run_cmd(13'h200, 8'd7, 1'b1, 1'b1);
    n_total++; if (r_timeout || w_beats !== 8 || wlast_pos !== 7 || r_sts_err !== 1'b0)
      $display("FAIL rnd_wr: timeout %b beats %0d lastpos %0d err %b want 0 8 7 0", r_timeout, w_beats, wlast_pos, r_sts_err); else n_pass++;
    run_cmd(13'h200, 8'd7, 1'b0, 1'b1);
    n_total++; if (r_timeout || r_rd_n !== 8)
      $display("FAIL rnd_rd_count: timeout %b beats %0d want 0 8", r_timeout, r_rd_n); else n_pass++;
    for (int i = 0; i < 8; i++)
      if (r_rd_data[i] !== 32'hA0 + 32'(i) || r_rd_last[i] !== (i == 7)) bad++;
    n_total++; if (bad !== 0) $display("FAIL rnd_rd_data: %0d bad beats want 0", bad); else n_pass++;
    slv_rnd = 0;
  endtask

  task automatic test_len0_unaligned();
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'b0011;
    clear_logs();
    run_cmd(13'h103, 8'd0, 1'b1, 1'b0);
    n_total++; if (r_timeout || last_awaddr !== 13'h100 || last_awlen !== 8'd0 || w_beats !== 1 || wlast_pos !== 0)
      $display("FAIL len0_wr: addr %h len %0d beats %0d lastpos %0d want 100 0 1 0", last_awaddr, last_awlen, w_beats, wlast_pos); else n_pass++;
    run_cmd(13'h102, 8'd0, 1'b0, 1'b0);
    n_total++; if (r_timeout || last_araddr !== 13'h100 || r_rd_n !== 1 || r_rd_data[0] !== 32'h0000BEEF || r_rd_last[0] !== 1'b1)
      $display("FAIL len0_rd: addr %h beats %0d data %h last %b want 100 1 0000beef 1", last_araddr, r_rd_n, r_rd_data[0], r_rd_last[0]); else n_pass++;
  endtask

  task automatic test_rlast_error();
    slv_rlast_beat = 1;
    run_cmd(13'h010, 8'd3, 1'b0, 1'b0);
    slv_rlast_beat = -1;
    n_total++; if (r_timeout || r_rd_n !== 4 || r_rd_data[3] !== 32'd4 || r_rd_last[3] !== 1'b1)
      $display("FAIL rlast_beats: beats %0d data3 %h last3 %b want 4 4 1", r_rd_n, r_rd_data[3], r_rd_last[3]); else n_pass++;
    n_total++; if (r_sts_err !== 1'b1 || r_sts_resp !== 2'b00)
      $display("FAIL rlast_status: err %b resp %b want 1 00", r_sts_err, r_sts_resp); else n_pass++;
  endtask

  task automatic test_resp_id_error();
    slv_rresp_beat = 2;
    run_cmd(13'h010, 8'd3, 1'b0, 1'b0);
    slv_rresp_beat = -1;
    n_total++; if (r_timeout || r_sts_resp !== 2'b10 || r_sts_err !== 1'b0)
      $display("FAIL rresp_max: resp %b err %b want 10 0", r_sts_resp, r_sts_err); else n_pass++;
    wr_data[0] = 32'h1; wr_data[1] = 32'h2; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    slv_id = 8'h05;
    run_cmd(13'h300, 8'd1, 1'b1, 1'b0);
    slv_id = 8'h00;
    n_total++; if (r_timeout || r_sts_err !== 1'b1 || r_sts_resp !== 2'b00)
      $display("FAIL bid_error: err %b resp %b want 1 00", r_sts_err, r_sts_resp); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int  b = 0;
    int  cyc = 0;
    bit  accepted = 0;
    bit  sts_seen = 0;
    int  bad = 0;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h11 * 32'(i + 1); wr_strb[i] = 4'hF; end
    clear_logs();
    while (b < 2 && cyc < 200) begin
      @(negedge clk);
      cmd_addr = 13'h400; cmd_len = 8'd3; cmd_write = 1; cmd_valid = !accepted;
      s_wr_valid = accepted; s_wr_data = wr_data[b[7:0]]; s_wr_strb = 4'hF;
      #1;
      if (s_wr_valid && s_wr_ready) b++;
      if (!accepted && cmd_ready) accepted = 1;
      cyc++;
    end
    n_total++; if (b !== 2) $display("FAIL mid_rst_setup: beats %0d want 2", b); else n_pass++;
    @(negedge clk);
    cmd_valid = 0; rst = 1; s_wr_valid = 1; s_wr_data = wr_data[2];
    #1;
    n_total++; if (m_axi_wvalid !== 1'b0 || m_axi_awvalid !== 1'b0 || s_wr_ready !== 1'b0 || cmd_ready !== 1'b0)
      $display("FAIL mid_rst_outputs: wvalid %b awvalid %b s_wr_ready %b cmd_ready %b want 0 0 0 0",
               m_axi_wvalid, m_axi_awvalid, s_wr_ready, cmd_ready); else n_pass++;
    if (sts_valid) sts_seen = 1;
    repeat (3) begin @(negedge clk); #1; if (sts_valid) sts_seen = 1; end
    @(negedge clk);
    rst = 0; s_wr_valid = 0;
    #1;
    if (sts_valid) sts_seen = 1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL mid_rst_release: cmd_ready %b want 1", cmd_ready); else n_pass++;
    n_total++; if (sts_seen !== 1'b0 || w_beats !== 2)
      $display("FAIL mid_rst_quiet: sts_seen %b beats %0d want 0 2", sts_seen, w_beats); else n_pass++;
    clear_logs();
    run_cmd(13'h400, 8'd3, 1'b1, 1'b0);
    n_total++; if (r_timeout || w_beats !== 4 || wlast_pos !== 3 || r_sts_err !== 1'b0 || r_sts_resp !== 2'b00)
      $display("FAIL mid_rst_next_wr: timeout %b beats %0d lastpos %0d err %b resp %b want 0 4 3 0 00",
               r_timeout, w_beats, wlast_pos, r_sts_err, r_sts_resp); else n_pass++;
    run_cmd(13'h400, 8'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) if (r_rd_data[i] !== 32'h11 * 32'(i + 1)) bad++;
    n_total++; if (r_timeout || r_rd_n !== 4 || bad !== 0)
      $display("FAIL mid_rst_readback: beats %0d bad %0d want 4 0", r_rd_n, bad); else n_pass++;
  endtask

  initial begin
    rst = 1;
    cmd_addr = '0; cmd_len = '0; cmd_write = 0; cmd_valid = 0;
    s_wr_data = '0; s_wr_strb = '0; s_wr_valid = 0; m_rd_ready = 0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_4k_boundary();
    test_random_stream();
    test_len0_unaligned();
    test_rlast_error();
    test_resp_id_error();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
